// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engines on the IO-path memory.
// Holds the read-side state enum and the default memory geometry so the
// future write-side engine can reuse the same constants.
// No ports: the package only holds types and constants.
package dma_pkg;

   localparam int DMA_ADDR_W    = 16;
   localparam int DMA_DATA_W    = 8;
   localparam int DMA_MEM_DEPTH = 32768;
   localparam int DMA_MEM_LAT   = 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      PRESENT,
      DONE
   } dma_state_e;

endpackage

// File: rtl/dma_block_reader_if.sv
// Memory-port and output-stream bundle for the DMA block reader.
// Ports (signals):
//   mem_address, mem_read_signal, mem_write_signal : engine -> memory
//   mem_dataout                                    : memory -> engine
//   out_data, out_valid, out_last                  : engine -> consumer
//   out_ready                                      : consumer -> engine
// Modports: master = DMA engine side, slave = memory/consumer side.
interface dma_block_reader_if
   import dma_pkg::*;
#(
   parameter int ADDR_W = DMA_ADDR_W,
   parameter int DATA_W = DMA_DATA_W
) ();

   logic [ADDR_W-1:0] mem_address;
   logic              mem_read_signal;
   logic              mem_write_signal;
   logic [DATA_W-1:0] mem_dataout;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output mem_address, mem_read_signal, mem_write_signal,
      output out_data, out_valid, out_last,
      input  mem_dataout, out_ready
   );

   modport slave (
      input  mem_address, mem_read_signal, mem_write_signal,
      input  out_data, out_valid, out_last,
      output mem_dataout, out_ready
   );

endinterface

// File: rtl/dma_block_reader.sv
// DMA read initiator: takes a (src_addr, length) command, reads the bytes
// one at a time from the byte-wide memory and streams them out on a
// valid/ready port with out_last on the final byte.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : command strobe, only looked at while idle
//   src_addr, length  : command (first byte address, byte count, 0 legal)
//   busy, done, err   : status (busy while active, one-cycle done pulse,
//                       err = last command was out of range)
//   bus (master)      : memory read port and output stream
module dma_block_reader
   import dma_pkg::*;
#(
   parameter int ADDR_W    = DMA_ADDR_W,
   parameter int DATA_W    = DMA_DATA_W,
   parameter int MEM_DEPTH = DMA_MEM_DEPTH,
   parameter int MEM_LAT   = DMA_MEM_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   output logic              err,
   dma_block_reader_if.master bus
);

   localparam int              WAIT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LAT - 1);
   localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

   dma_state_e        state, state_next;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] remaining;
   logic [ADDR_W-1:0] addr_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic [DATA_W-1:0] data_q;
   logic              err_q;
   logic [ADDR_W:0]   end_addr;
   logic              cmd_bad;
   logic              cmd_accept;
   logic              read_last;
   logic              handshake;

   // One extra bit so a command ending exactly at the top of the address
   // space cannot wrap and slip past the range check.
   assign end_addr = {1'b0, src_addr} + {1'b0, length};

   // Next-state logic plus the single-cycle event flags the datapath uses.
   // Zero-length commands take the DONE path without touching err.
   always_comb begin
      state_next = state;
      cmd_bad    = 1'b0;
      cmd_accept = 1'b0;
      read_last  = 1'b0;
      handshake  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (length == '0) begin
                  state_next = DONE;
               end else if (end_addr > DEPTH_LIM) begin
                  cmd_bad    = 1'b1;
                  state_next = DONE;
               end else begin
                  cmd_accept = 1'b1;
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (wait_cnt == WAIT_LAST) begin
               read_last  = 1'b1;
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (bus.out_ready) begin
               handshake  = 1'b1;
               state_next = (remaining == ADDR_W'(1)) ? DONE : ISSUE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset mid-command simply drops back to IDLE so no
   // done pulse is produced for the aborted command.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Command datapath. addr_q drives the memory and is only reloaded when a
   // new read is about to start, so the address holds outside ISSUE while
   // cur_addr already points at the next byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr  <= '0;
         remaining <= '0;
         addr_q    <= '0;
         wait_cnt  <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         if (cmd_bad) begin
            err_q <= 1'b1;
         end
         if (cmd_accept) begin
            err_q     <= 1'b0;
            cur_addr  <= src_addr;
            remaining <= length;
            addr_q    <= src_addr;
            wait_cnt  <= '0;
         end
         if (state == ISSUE) begin
            wait_cnt <= read_last ? '0 : wait_cnt + 1'b1;
         end
         if (read_last) begin
            data_q <= bus.mem_dataout;
         end
         if (handshake) begin
            remaining <= remaining - 1'b1;
            cur_addr  <= cur_addr + 1'b1;
            if (remaining != ADDR_W'(1)) begin
               addr_q <= cur_addr + 1'b1;
            end
         end
      end
   end

   assign bus.mem_address      = addr_q;
   assign bus.mem_read_signal  = (state == ISSUE);
   assign bus.mem_write_signal = 1'b0;
   assign bus.out_data         = data_q;
   assign bus.out_valid        = (state == PRESENT);
   assign bus.out_last         = (state == PRESENT) && (remaining == ADDR_W'(1));
   assign busy                 = (state != IDLE);
   assign done                 = (state == DONE);
   assign err                  = err_q;

endmodule
